quad_step_decoder: RTL and testbench

- Front end for the up/down counter: converts raw two-channel quadrature encoder inputs into a one-cycle step pulse plus a held direction bit.
- The counter's enable is driven by step, and its Up_Down input by up_down.
- Block contents: input synchronisation, per-channel glitch filtering, an init/run state machine, Gray-transition decode, and a saturating error counter.

---
 rtl/quad_step_decoder_pkg.sv | 27 ++
 rtl/quad_step_decoder_glitch_filter.sv | 56 +++++
 rtl/quad_step_decoder.sv | 128 ++++++++++++
 tb/tb_quad_step_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/quad_step_decoder_pkg.sv
// Shared types and helpers for the quadrature step decoder.
package quad_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // {A, B} quadrature positions, listed in up-count (A leads) order
  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  localparam int FILTER_CYCLES_DEF = 4;

  // Successor of q when the encoder turns in the up direction
  function automatic logic [1:0] next_up(input logic [1:0] q);
    case (q)
      Q00:     return Q10;
      Q10:     return Q11;
      Q11:     return Q01;
      default: return Q00;
    endcase
  endfunction

endpackage

// File: rtl/quad_step_decoder_glitch_filter.sv
// One encoder channel: 2-flop synchroniser followed by a stable-count filter.
// The filtered level only follows the synchronised input after it has held a
// new value for FILTER_CYCLES consecutive edges; o_upd pulses for one cycle
// right after each accepted change.
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int FILTER_W      = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_filt,
  output logic o_upd,
  output logic o_stable
);

  logic                r_sync_p0;
  logic                r_sync_p1;
  logic                r_filt;
  logic                r_upd;
  logic [FILTER_W-1:0] r_cnt;

  // Synchronise the raw input, then count how long it has disagreed with the filtered level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_filt    <= 1'b0;
      r_upd     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync_p0 <= i_raw;
      r_sync_p1 <= r_sync_p0;
      if (r_sync_p1 != r_filt) begin
        if (r_cnt == FILTER_W'(FILTER_CYCLES - 1)) begin
          r_filt <= r_sync_p1;
          r_cnt  <= '0;
          r_upd  <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + FILTER_W'(1);
          r_upd  <= 1'b0;
        end
      end else begin
        r_cnt <= '0;
        r_upd <= 1'b0;
      end
    end
  end

  assign o_filt   = r_filt;
  assign o_upd    = r_upd;
  assign o_stable = (r_sync_p1 == r_filt) && (r_cnt == '0);

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: filters both channels, captures the initial
// position silently, then turns each Gray transition into a one-cycle step
// (with held direction) or, for a double-bit jump, a one-cycle err pulse.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int FILTER_W      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       err_clr,
  output logic       step,
  output logic       up_down,
  output logic       err,
  output logic [7:0] err_count,
  output logic       ready
);

  logic                w_filt_a, w_filt_b;
  logic                w_upd_a, w_upd_b;
  logic                w_stable_a, w_stable_b;
  logic [1:0]          w_ab;
  logic [1:0]          w_diff;

  state_t              r_state;
  logic [1:0]          r_prev_ab;
  logic [FILTER_W-1:0] r_stab_cnt;
  logic                r_step;
  logic                r_up_down;
  logic                r_err;
  logic                r_ready;
  logic [7:0]          r_err_count;

  quad_glitch_filter #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .FILTER_W      (FILTER_W)
  ) u_filt_a (
    .clock    (clock),
    .reset    (reset),
    .i_raw    (enc_a),
    .o_filt   (w_filt_a),
    .o_upd    (w_upd_a),
    .o_stable (w_stable_a)
  );

  quad_glitch_filter #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .FILTER_W      (FILTER_W)
  ) u_filt_b (
    .clock    (clock),
    .reset    (reset),
    .i_raw    (enc_b),
    .o_filt   (w_filt_b),
    .o_upd    (w_upd_b),
    .o_stable (w_stable_b)
  );

  assign w_ab   = {w_filt_a, w_filt_b};
  assign w_diff = r_prev_ab ^ w_ab;

  // Init/run sequencing and Gray-transition decode with registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= INIT;
      r_prev_ab  <= Q00;
      r_stab_cnt <= '0;
      r_step     <= 1'b0;
      r_up_down  <= 1'b1;
      r_err      <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        INIT: begin
          // Track the position silently until both channels have settled
          r_prev_ab <= w_ab;
          if (w_stable_a && w_stable_b) begin
            if (r_stab_cnt == FILTER_W'(FILTER_CYCLES - 1)) begin
              r_state    <= RUN;
              r_ready    <= 1'b1;
              r_stab_cnt <= '0;
            end else begin
              r_stab_cnt <= r_stab_cnt + FILTER_W'(1);
            end
          end else begin
            r_stab_cnt <= '0;
          end
        end
        RUN: begin
          if (w_upd_a || w_upd_b) begin
            r_prev_ab <= w_ab;
            case (w_diff)
              2'b11: r_err <= 1'b1;
              2'b01, 2'b10: begin
                r_step    <= 1'b1;
                r_up_down <= (w_ab == next_up(r_prev_ab));
              end
              default: ;
            endcase
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  // Saturating error counter; a clear request wins over a coincident error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if (err_clr) begin
      r_err_count <= 8'd0;
    end else if (r_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign step      = r_step;
  assign up_down   = r_up_down;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign ready     = r_ready;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with FILTER_CYCLES = 4.
module tb_quad_step_decoder;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       enc_a   = 1'b0;
  logic       enc_b   = 1'b0;
  logic       err_clr = 1'b0;
  logic       step;
  logic       up_down;
  logic       err;
  logic [7:0] err_count;
  logic       ready;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_step   = 0;
  int n_err    = 0;
  int n_both   = 0;
  int last_step_cyc = -1;
  int p0, s_step, s_err;

  always #5 clock = ~clock;

  quad_step_decoder #(
    .FILTER_CYCLES (4),
    .FILTER_W      (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .err_clr   (err_clr),
    .step      (step),
    .up_down   (up_down),
    .err       (err),
    .err_count (err_count),
    .ready     (ready)
  );

  // Edge counter and pulse monitor; last_step_cyc is the edge that started the step cycle
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (step) begin
      n_step        <= n_step + 1;
      last_step_cyc <= cyc;
    end
    if (err) n_err <= n_err + 1;
    if (step && err) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic toggle_both();
    enc_a = ~enc_a;
    enc_b = ~enc_b;
  endtask

  initial begin
    // Reset values with the encoder sitting at 11
    enc_a = 1'b1; enc_b = 1'b1;
    waitn(2);
    check("rst_step", step, 0);
    check("rst_up_down", up_down, 1);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_ready", ready, 0);

    // Silent capture of 11
    reset = 1'b0;
    waitn(5);
    check("init_ready_low", ready, 0);
    waitn(15);
    check("init_ready_high", ready, 1);
    check("init_no_step", n_step, 0);
    check("init_no_err", n_err, 0);

    // Recapture at 00 through a reset
    reset = 1'b1;
    enc_a = 1'b0; enc_b = 1'b0;
    #1;
    check("rst_ready_immediate", ready, 0);
    waitn(2);
    reset = 1'b0;
    waitn(10);
    check("init00_ready", ready, 1);
    check("init00_no_step", n_step, 0);

    // Up sequence 00->10->11->01->00
    s_step = n_step;
    p0 = cyc;
    enc_a = 1'b1;
    waitn(10);
    check("up1_latency", last_step_cyc, p0 + 7);
    check("up1_count", n_step - s_step, 1);
    check("up1_dir", up_down, 1);
    enc_b = 1'b1;
    waitn(10);
    check("up2_count", n_step - s_step, 2);
    check("up2_dir", up_down, 1);
    enc_a = 1'b0;
    waitn(10);
    check("up3_count", n_step - s_step, 3);
    check("up3_dir", up_down, 1);
    enc_b = 1'b0;
    waitn(10);
    check("up4_count", n_step - s_step, 4);
    check("up4_dir", up_down, 1);
    check("up_no_err", n_err, 0);

    // Down sequence 00->01->11->10, idle, then back to 00
    s_step = n_step;
    enc_b = 1'b1;
    waitn(10);
    check("dn1_count", n_step - s_step, 1);
    check("dn1_dir", up_down, 0);
    enc_a = 1'b1;
    waitn(10);
    check("dn2_count", n_step - s_step, 2);
    enc_b = 1'b0;
    waitn(10);
    check("dn3_count", n_step - s_step, 3);
    waitn(50);
    check("dn_idle_dir", up_down, 0);
    check("dn_idle_count", n_step - s_step, 3);
    enc_a = 1'b0;
    waitn(10);
    check("dn4_count", n_step - s_step, 4);
    check("dn4_dir", up_down, 0);

    // Glitch filter: 3-cycle bounce rejected, 4-cycle pulse accepted
    s_step = n_step;
    s_err  = n_err;
    enc_a = 1'b1;
    waitn(3);
    enc_a = 1'b0;
    waitn(15);
    check("bounce3_no_step", n_step - s_step, 0);
    check("bounce3_no_err", n_err - s_err, 0);
    enc_a = 1'b1;
    waitn(4);
    enc_a = 1'b0;
    waitn(4);
    check("pulse4_step", n_step - s_step, 1);
    check("pulse4_dir", up_down, 1);
    waitn(10);
    check("pulse4_return_step", n_step - s_step, 2);
    check("pulse4_return_dir", up_down, 0);
    check("pulse4_no_err", n_err - s_err, 0);

    // Double-bit transitions: err pulses and saturation
    s_step = n_step;
    s_err  = n_err;
    toggle_both();
    waitn(8);
    check("err_first_count", err_count, 1);
    check("err_first_pulse", n_err - s_err, 1);
    for (int i = 1; i < 300; i++) begin
      toggle_both();
      waitn(8);
    end
    check("err_total", n_err - s_err, 300);
    check("err_no_step", n_step - s_step, 0);
    check("err_saturated", err_count, 255);
    check("err_dir_held", up_down, 0);

    // Clear coincident with an err pulse
    toggle_both();
    waitn(7);
    check("clr_err_pulse", err, 1);
    err_clr = 1'b1;
    waitn(1);
    err_clr = 1'b0;
    check("clr_wins", err_count, 0);
    check("clr_err_one_cycle", err, 0);
    waitn(5);
    check("clr_stays", err_count, 0);
    toggle_both();
    waitn(8);
    check("clr_recount", err_count, 1);

    // Reset in the middle of a filter count
    enc_a = 1'b1;
    waitn(4);
    s_step = n_step;
    s_err  = n_err;
    reset = 1'b1;
    #1;
    check("midrst_step", step, 0);
    check("midrst_err", err, 0);
    check("midrst_up_down", up_down, 1);
    check("midrst_ready", ready, 0);
    check("midrst_err_count", err_count, 0);
    waitn(2);
    reset = 1'b0;
    waitn(3);
    check("midrst_recapture_ready_low", ready, 0);
    waitn(20);
    check("midrst_recapture_ready", ready, 1);
    check("midrst_no_step", n_step - s_step, 0);
    check("midrst_no_err", n_err - s_err, 0);
    enc_a = 1'b0;
    waitn(10);
    check("midrst_post_step", n_step - s_step, 1);
    check("midrst_post_dir", up_down, 0);

    check("never_step_and_err", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
